// File: rtl/nt_sched_pkg.sv
// Shared definitions for the neurotransmitter level scheduler.
// Holds the transmitter count and index map, the scheduler FSM state type,
// and the layout of the quantized level bus (2 bits per transmitter).
package nt_sched_pkg;

    localparam int NUM_NT     = 5;
    localparam int SLOT_W     = 3;

    // Transmitter index map, shared by every per-transmitter vector.
    localparam int NT_CORT    = 0;
    localparam int NT_DOP     = 1;
    localparam int NT_GABA    = 2;
    localparam int NT_NE      = 3;
    localparam int NT_SER     = 4;

    // Quantized level bus layout.
    localparam int NT_FIELD_W = 2;
    localparam int NT_BUS_W   = NUM_NT * NT_FIELD_W;
    localparam int NT_CORT_LSB = NT_CORT * NT_FIELD_W;
    localparam int NT_DOP_LSB  = NT_DOP  * NT_FIELD_W;
    localparam int NT_GABA_LSB = NT_GABA * NT_FIELD_W;
    localparam int NT_NE_LSB   = NT_NE   * NT_FIELD_W;
    localparam int NT_SER_LSB  = NT_SER  * NT_FIELD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    // LSB position of a transmitter's field in the quantized bus.
    function automatic int nt_field_lsb(input int idx);
        return idx * NT_FIELD_W;
    endfunction

endpackage

// File: rtl/nt_sat_stepper.sv
// Shared saturating update datapath.
// Ports:
//   level_i  current level
//   inc_i    increment request
//   dec_i    decrement request (inc and dec together hold the level)
//   step_i   step magnitude
//   level_o  next level, clamped to 0 .. 2^LEVEL_W-1
module nt_sat_stepper #(
    parameter int LEVEL_W = 8
) (
    input  logic [LEVEL_W-1:0] level_i,
    input  logic               inc_i,
    input  logic               dec_i,
    input  logic [LEVEL_W-1:0] step_i,
    output logic [LEVEL_W-1:0] level_o
);

    logic [LEVEL_W:0] sum_s;
    logic [LEVEL_W:0] diff_s;

    // One extra bit catches carry (overflow) and borrow (underflow) for clamping.
    always_comb begin
        sum_s   = {1'b0, level_i} + {1'b0, step_i};
        diff_s  = {1'b0, level_i} - {1'b0, step_i};
        level_o = level_i;
        if (inc_i && !dec_i) begin
            level_o = sum_s[LEVEL_W] ? {LEVEL_W{1'b1}} : sum_s[LEVEL_W-1:0];
        end else if (dec_i && !inc_i) begin
            level_o = diff_s[LEVEL_W] ? {LEVEL_W{1'b0}} : diff_s[LEVEL_W-1:0];
        end else begin
            level_o = level_i;
        end
    end

endmodule

// File: rtl/nt_level_scheduler.sv
// Owns the five neurotransmitter level registers and sequences one shared
// saturating stepper through them, one transmitter per cycle, once per tick.
// Ports:
//   clk, rst                 clock, async active-high reset
//   en                       allows new rounds to start
//   req_inc/req_dec/req_fast per-transmitter requests (latched at round start)
//   dbg_sel, dbg_level       combinational readback of a live raw level
//   neurotransmitter_level   quantized snapshot, updated only at round end
//   round_done               one-cycle pulse alongside a new snapshot
//   overrun                  sticky: a tick arrived during a round
module nt_level_scheduler
    import nt_sched_pkg::*;
#(
    parameter int LEVEL_W     = 8,
    parameter int TICK_DIV    = 16,
    parameter int SLOW_DIV    = 4,
    parameter int STEP_SLOW   = 1,
    parameter int STEP_FAST   = 4,
    parameter int RESET_LEVEL = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_NT-1:0]   req_inc,
    input  logic [NUM_NT-1:0]   req_dec,
    input  logic [NUM_NT-1:0]   req_fast,
    input  logic [SLOT_W-1:0]   dbg_sel,
    output logic [NT_BUS_W-1:0] neurotransmitter_level,
    output logic [LEVEL_W-1:0]  dbg_level,
    output logic                round_done,
    output logic                overrun
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RC_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [LEVEL_W-1:0]    RST_LVL   = LEVEL_W'(RESET_LEVEL);
    localparam logic [NT_FIELD_W-1:0] RST_FIELD = RST_LVL[LEVEL_W-1 -: NT_FIELD_W];
    localparam logic [LEVEL_W-1:0]    SLOW_V    = LEVEL_W'(STEP_SLOW);
    localparam logic [LEVEL_W-1:0]    FAST_V    = LEVEL_W'(STEP_FAST);

    sched_state_e          state_q, state_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [PS_W-1:0]       ps_q, ps_d;
    logic [RC_W-1:0]       round_cnt_q, round_cnt_d;
    logic [LEVEL_W-1:0]    level_q [NUM_NT];
    logic [LEVEL_W-1:0]    level_d [NUM_NT];
    logic [NUM_NT-1:0]     inc_q, dec_q, fast_q;
    logic [NT_BUS_W-1:0]   nt_level_q, nt_level_d, snap_s;
    logic                  round_done_q, overrun_q;

    logic                  tick_s, latch_s, upd_s, commit_s, drop_s;
    logic [LEVEL_W-1:0]    cur_level_s, step_s, next_level_s;
    logic                  cur_inc_s, cur_dec_s, cur_fast_s;

    assign tick_s = (ps_q == PS_W'(TICK_DIV - 1));

    // Free-running prescaler, independent of en.
    always_comb begin
        ps_d = tick_s ? {PS_W{1'b0}} : ps_q + PS_W'(1);
    end

    // Scheduler FSM next-state and control strobes.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        latch_s  = 1'b0;
        upd_s    = 1'b0;
        commit_s = 1'b0;
        drop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_s && en) begin
                    state_d = SCAN;
                    slot_d  = 3'd0;
                    latch_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                upd_s  = 1'b1;
                drop_s = tick_s;
                if (slot_q == SLOT_W'(NUM_NT - 1)) begin
                    state_d = DONE;
                    slot_d  = 3'd0;
                end else begin
                    slot_d = slot_q + 3'd1;
                end
            end
            DONE: begin
                commit_s = 1'b1;
                drop_s   = tick_s;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                slot_d  = 3'd0;
            end
        endcase
    end

    // Slot mux into the shared stepper, step selection, and level write-back.
    always_comb begin
        cur_level_s = {LEVEL_W{1'b0}};
        cur_inc_s   = 1'b0;
        cur_dec_s   = 1'b0;
        cur_fast_s  = 1'b0;
        for (int i = 0; i < NUM_NT; i++) begin
            cur_level_s = (slot_q == SLOT_W'(i)) ? level_q[i] : cur_level_s;
            cur_inc_s   = (slot_q == SLOT_W'(i)) ? inc_q[i]   : cur_inc_s;
            cur_dec_s   = (slot_q == SLOT_W'(i)) ? dec_q[i]   : cur_dec_s;
            cur_fast_s  = (slot_q == SLOT_W'(i)) ? fast_q[i]  : cur_fast_s;
        end
        // Slow steps only take effect in the first round of each SLOW_DIV group.
        step_s = cur_fast_s ? FAST_V :
                 ((round_cnt_q == {RC_W{1'b0}}) ? SLOW_V : {LEVEL_W{1'b0}});
        for (int i = 0; i < NUM_NT; i++) begin
            level_d[i] = (upd_s && (slot_q == SLOT_W'(i))) ? next_level_s : level_q[i];
        end
    end

    nt_sat_stepper #(
        .LEVEL_W (LEVEL_W)
    ) u_stepper (
        .level_i (cur_level_s),
        .inc_i   (cur_inc_s),
        .dec_i   (cur_dec_s),
        .step_i  (step_s),
        .level_o (next_level_s)
    );

    // Snapshot packing, round counter and debug readback.
    always_comb begin
        snap_s    = {NT_BUS_W{1'b0}};
        dbg_level = {LEVEL_W{1'b0}};
        for (int i = 0; i < NUM_NT; i++) begin
            snap_s[nt_field_lsb(i) +: NT_FIELD_W] = level_q[i][LEVEL_W-1 -: NT_FIELD_W];
            dbg_level = (dbg_sel == SLOT_W'(i)) ? level_q[i] : dbg_level;
        end
        nt_level_d = commit_s ? snap_s : nt_level_q;
        if (commit_s) begin
            round_cnt_d = (round_cnt_q == RC_W'(SLOW_DIV - 1)) ? {RC_W{1'b0}}
                                                                : round_cnt_q + RC_W'(1);
        end else begin
            round_cnt_d = round_cnt_q;
        end
    end

    // Control state: FSM, prescaler, round counter and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            slot_q       <= 3'd0;
            ps_q         <= {PS_W{1'b0}};
            round_cnt_q  <= {RC_W{1'b0}};
            round_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            nt_level_q   <= {NUM_NT{RST_FIELD}};
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            ps_q         <= ps_d;
            round_cnt_q  <= round_cnt_d;
            round_done_q <= commit_s;
            overrun_q    <= overrun_q | drop_s;
            nt_level_q   <= nt_level_d;
        end
    end

    // Level registers and the request latch taken at round start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_NT; i++) begin
                level_q[i] <= RST_LVL;
            end
            inc_q  <= {NUM_NT{1'b0}};
            dec_q  <= {NUM_NT{1'b0}};
            fast_q <= {NUM_NT{1'b0}};
        end else begin
            for (int i = 0; i < NUM_NT; i++) begin
                level_q[i] <= level_d[i];
            end
            inc_q  <= latch_s ? req_inc  : inc_q;
            dec_q  <= latch_s ? req_dec  : dec_q;
            fast_q <= latch_s ? req_fast : fast_q;
        end
    end

    assign neurotransmitter_level = nt_level_q;
    assign round_done             = round_done_q;
    assign overrun                = overrun_q;

endmodule

// File: doc/nt_level_scheduler.md
Name: nt_level_scheduler

Overview:
- Owns the five neurotransmitter level registers: cortisol, dopamine, GABA, norepinephrine and serotonin.
- Sequences the shared saturating update datapath through them, one transmitter per cycle, once per scheduler tick.
- Each update applies the inc/dec/fast request from that transmitter's regulator.
- Publishes a coherent 10-bit quantized level bus, which feeds back into every nt_*_regulator.

Parameters:
- LEVEL_W, 8: width of each internal level register.
- TICK_DIV, 16: clock cycles per scheduler tick. Legal range is 8 or more.
- SLOW_DIV, 4: slow (non-fast) requests are applied only in rounds where round_cnt == 0.
- STEP_SLOW, 1: magnitude of a slow step.
- STEP_FAST, 4: magnitude of a fast step.
- RESET_LEVEL, 128: reset value of every level register.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: enables the start of new rounds.
- req_inc, input, 5: per-transmitter increment request. Index order is 0 CORT, 1 DOP, 2 GABA, 3 NE, 4 SER.
- req_dec, input, 5: per-transmitter decrement request, same index order.
- req_fast, input, 5: per-transmitter fast-step qualifier, same index order.
- dbg_sel, input, 3: selects a raw level for readback. Values 5–7 read 0.
- neurotransmitter_level, output, 10: quantized snapshot, 2 bits per transmitter. CORT [1:0], DOP [3:2], GABA [5:4], NE [7:6], SER [9:8].
- dbg_level, output, LEVEL_W: raw live level selected by dbg_sel (combinational).
- round_done, output, 1: one-cycle pulse, coincident with a new snapshot.
- overrun, output, 1: sticky flag; a tick arrived while a round was in progress.

Behaviour:
- Reset (async, immediate):
  - All level registers = RESET_LEVEL.
  - neurotransmitter_level = 10'h2AA (each field = RESET_LEVEL[LEVEL_W-1:LEVEL_W-2] = 2'b10).
  - Prescaler = 0, round_cnt = 0, state = IDLE.
  - round_done = 0, overrun = 0.
- Prescaler:
  - Free-running counter, 0 to TICK_DIV-1.
  - tick is high in the cycle where the count equals TICK_DIV-1.
  - Runs regardless of en.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: if tick && en, go to SCAN with slot = 0. On the same edge, latch req_inc, req_dec and req_fast into internal request registers.
  - SCAN: on each edge, update level[slot] from the latched requests, then advance the slot. The update edge for slot 4 also goes to DONE.
  - DONE: on this edge, copy the top 2 bits of each level into neurotransmitter_level. Set round_done = 1 for the following cycle, set round_cnt = (round_cnt + 1) mod SLOW_DIV, and go to IDLE.
- Latency:
  - The tick-sampling edge is E0. Slots 0–4 update on E1–E5.
  - The snapshot is taken on E6; round_done is high in the cycle after E6.
  - A round occupies 7 cycles, within the TICK_DIV >= 8 minimum.
- Per-slot step rule (i = slot):
  - inc && dec: hold (conflict; no change).
  - inc only: add the step.
  - dec only: subtract the step.
  - Neither: hold.
  - step = STEP_FAST if fast[i]; otherwise STEP_SLOW if round_cnt == 0; otherwise 0.
- Arithmetic:
  - Computed in LEVEL_W+1 bits.
  - Result saturates to the range 0 to 2^LEVEL_W - 1. It never wraps.
- Snapshot coherence:
  - neurotransmitter_level changes only on the DONE edge.
  - The regulators therefore never see a partially updated round.
- en deasserted mid-round: the round completes normally; no new round starts.
- tick while in SCAN or DONE: the tick is dropped, overrun is set to 1, and the round is unaffected. overrun is cleared only by rst.
- Reset mid-round: everything returns to reset values; there is no partial commit.

Decomposition:
- Package nt_sched_pkg holds:
  - NUM_NT = 5.
  - Index constants NT_CORT, NT_DOP, NT_GABA, NT_NE, NT_SER.
  - The state enum IDLE/SCAN/DONE.
  - The field-offset constants for neurotransmitter_level.
- One sub-module, nt_sat_stepper (combinational).
  - Inputs: level, inc, dec, step.
  - Output: saturated next level.
  - It is the shared datapath, instantiated once and muxed by slot.

Test Plan:
- Reset check: after rst, neurotransmitter_level = 10'h2AA and dbg_level = 128 for dbg_sel 0–4. Values 5–7 read 0, and no round_done occurs while en = 0.
- Fast increment: en = 1, req_inc[1] = 1, req_fast[1] = 1 for one round. DOP = 132 at round_done, and neurotransmitter_level[3:2] stays 2'b10.
- Slow decrement gating: req_dec[0] = 1, fast = 0, for 4 rounds from reset. CORT = 127 after the first round, then is unchanged in rounds 2–4. neurotransmitter_level[1:0] = 2'b01 from the first round_done.
- Saturation and conflict: hold req_inc[4] and req_fast[4] for 40 rounds; SER = 255 with no wrap and field [9:8] = 2'b11. Then set inc and dec together on GABA: GABA holds at 128.
- Snapshot timing: dbg_level shows DOP changing on E2, while neurotransmitter_level changes only on E6, together with the 1-cycle round_done pulse.
- Overrun and reset mid-round: with TICK_DIV forced to 4 via parameter override (below the legal minimum, test-only), overrun goes to 1 and stays there. Asserting rst during SCAN slot 2 returns all levels to 128 and clears overrun immediately.
